stopwatch_100hz: RTL and testbench

Downstream consumer of the 100 Hz divided clock produced by clk_generation_100Hz. Runs entirely in the clk_50MHz domain and detects rising edges of clk_100Hz to form a 10 ms tick. Keeps a BCD stopwatch in the form MM:SS.CC, with start/pause/clear control. Outputs feed the seven-segment display driver.

---
 rtl/stopwatch_100hz.sv | 180 ++++++++++++++++++
 tb/tb_stopwatch_100hz.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_100hz.sv
// ============================================================================
// stopwatch_100hz
// ----------------------------------------------------------------------------
// BCD stopwatch (MM:SS.CC) driven by the 100 Hz divider output. Everything
// runs in the clk_50MHz domain; rising edges of clk_100Hz are detected to
// form a single-cycle 10 ms tick. start_stop toggles run/pause, clear zeroes
// the count and returns to IDLE.
//
// Parameters:
//   MAX_MIN    highest minute value (1..99); MAX_MIN:59.99 wraps to 00:00.00
//
// Ports:
//   clk_50MHz  in   system clock
//   rst        in   synchronous, active-high reset
//   clk_100Hz  in   100 Hz square wave, synchronous to clk_50MHz
//   start_stop in   single-cycle pulse, toggles run/pause
//   clear      in   single-cycle pulse, zero count and go IDLE
//   lap        in   (LAP_HOLD_EN only) single-cycle pulse, toggles display hold
//   cs_bcd     out  centiseconds, two BCD digits
//   sec_bcd    out  seconds, two BCD digits (00..59)
//   min_bcd    out  minutes, two BCD digits (00..MAX_MIN)
//   running    out  high in RUN state
//   rollover   out  one-cycle pulse on wrap to 00:00.00
//
// Optional feature macro: LAP_HOLD_EN (lap-hold display freeze).
// ============================================================================
module stopwatch_100hz #(
    parameter int unsigned MAX_MIN = 59
) (
    input  logic       clk_50MHz,
    input  logic       rst,
    input  logic       clk_100Hz,
    input  logic       start_stop,
    input  logic       clear,
`ifdef LAP_HOLD_EN
    input  logic       lap,
`endif
    output logic [7:0] cs_bcd,
    output logic [7:0] sec_bcd,
    output logic [7:0] min_bcd,
    output logic       running,
    output logic       rollover
);

    localparam logic [7:0] MAX_MIN_BCD = 8'(((MAX_MIN / 10) << 4) | (MAX_MIN % 10));

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    state_t     state_q, state_d;
    logic       clk_d_q;
    logic       tick;
    logic [3:0] cs_u_q, cs_u_d, cs_t_q, cs_t_d;
    logic [3:0] sec_u_q, sec_u_d, sec_t_q, sec_t_d;
    logic [7:0] min_q, min_d;
    logic       running_q, running_d;
    logic       rollover_q, rollover_d;

    always_comb begin
        tick       = clk_100Hz & ~clk_d_q;
        state_d    = state_q;
        cs_u_d     = cs_u_q;
        cs_t_d     = cs_t_q;
        sec_u_d    = sec_u_q;
        sec_t_d    = sec_t_q;
        min_d      = min_q;
        rollover_d = 1'b0;

        if (clear) begin
            state_d = IDLE;
            cs_u_d  = '0;
            cs_t_d  = '0;
            sec_u_d = '0;
            sec_t_d = '0;
            min_d   = '0;
        end else begin
            // Counting uses the current state, so a tick coinciding with
            // start_stop counts only if we were already running.
            if (state_q == RUN && tick) begin
                if (cs_u_q != 4'd9) begin
                    cs_u_d = cs_u_q + 4'd1;
                end else begin
                    cs_u_d = '0;
                    if (cs_t_q != 4'd9) begin
                        cs_t_d = cs_t_q + 4'd1;
                    end else begin
                        cs_t_d = '0;
                        if (sec_u_q != 4'd9) begin
                            sec_u_d = sec_u_q + 4'd1;
                        end else begin
                            sec_u_d = '0;
                            if (sec_t_q != 4'd5) begin
                                sec_t_d = sec_t_q + 4'd1;
                            end else begin
                                sec_t_d = '0;
                                if (min_q == MAX_MIN_BCD) begin
                                    min_d      = '0;
                                    rollover_d = 1'b1;
                                end else if (min_q[3:0] == 4'd9) begin
                                    min_d = {min_q[7:4] + 4'd1, 4'd0};
                                end else begin
                                    min_d = {min_q[7:4], min_q[3:0] + 4'd1};
                                end
                            end
                        end
                    end
                end
            end
            if (start_stop) begin
                case (state_q)
                    RUN:     state_d = PAUSE;
                    default: state_d = RUN;
                endcase
            end
        end
        running_d = (state_d == RUN);
    end

    always_ff @(posedge clk_50MHz) begin
        if (rst) begin
            state_q    <= IDLE;
            clk_d_q    <= 1'b1;   // no spurious tick if clk_100Hz is high at release
            cs_u_q     <= '0;
            cs_t_q     <= '0;
            sec_u_q    <= '0;
            sec_t_q    <= '0;
            min_q      <= '0;
            running_q  <= 1'b0;
            rollover_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clk_d_q    <= clk_100Hz;
            cs_u_q     <= cs_u_d;
            cs_t_q     <= cs_t_d;
            sec_u_q    <= sec_u_d;
            sec_t_q    <= sec_t_d;
            min_q      <= min_d;
            running_q  <= running_d;
            rollover_q <= rollover_d;
        end
    end

    assign running  = running_q;
    assign rollover = rollover_q;

`ifdef LAP_HOLD_EN
    logic        hold_q, hold_d;
    logic [23:0] disp_q, disp_d;

    always_comb begin
        hold_d = hold_q;
        if (clear) begin
            hold_d = 1'b0;
        end else if (lap && state_q == RUN) begin
            hold_d = ~hold_q;
        end
        // While not held disp_q tracks the live count, so keeping disp_q on
        // the lap edge freezes exactly the value shown at that moment.
        disp_d = hold_d ? disp_q : {cs_t_d, cs_u_d, sec_t_d, sec_u_d, min_d};
    end

    always_ff @(posedge clk_50MHz) begin
        if (rst) begin
            hold_q <= 1'b0;
            disp_q <= '0;
        end else begin
            hold_q <= hold_d;
            disp_q <= disp_d;
        end
    end

    assign cs_bcd  = disp_q[23:16];
    assign sec_bcd = disp_q[15:8];
    assign min_bcd = disp_q[7:0];
`else
    assign cs_bcd  = {cs_t_q, cs_u_q};
    assign sec_bcd = {sec_t_q, sec_u_q};
    assign min_bcd = min_q;
`endif

endmodule

// File: tb/tb_stopwatch_100hz.sv
// ============================================================================
// tb_stopwatch_100hz
// ----------------------------------------------------------------------------
// Self-checking bench for stopwatch_100hz (built with MAX_MIN = 1). A
// behavioural model keeps the elapsed time as a plain integer number of
// centiseconds; expected output snapshots are pushed to a queue and popped
// when the DUT outputs are sampled on the falling clock edge.
// Exercises the lap-hold feature when LAP_HOLD_EN is defined.
// ============================================================================
module tb_stopwatch_100hz;

    localparam int unsigned MAX_MIN = 1;
    localparam int WRAP = (MAX_MIN + 1) * 6000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clk_100Hz = 1'b1;
    logic       start_stop = 1'b0;
    logic       clear = 1'b0;
`ifdef LAP_HOLD_EN
    logic       lap = 1'b0;
`endif
    logic [7:0] cs_bcd, sec_bcd, min_bcd;
    logic       running, rollover;

    stopwatch_100hz #(.MAX_MIN(MAX_MIN)) dut (
        .clk_50MHz (clk),
        .rst       (rst),
        .clk_100Hz (clk_100Hz),
        .start_stop(start_stop),
        .clear     (clear),
`ifdef LAP_HOLD_EN
        .lap       (lap),
`endif
        .cs_bcd    (cs_bcd),
        .sec_bcd   (sec_bcd),
        .min_bcd   (min_bcd),
        .running   (running),
        .rollover  (rollover)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] cs;
        logic [7:0] sec;
        logic [7:0] min;
        logic       run;
        logic       roll;
    } snap_t;

    snap_t sb_q[$];
    snap_t obs, expv;
    int    n_checks = 0;
    int    n_fail   = 0;
    int    m_t      = 0;   // model elapsed centiseconds
    int    m_state  = 0;   // 0 idle, 1 run, 2 pause
    int    m_hold   = 0;
    int    roll_cnt = 0;

    always @(negedge clk) if (rollover === 1'b1) roll_cnt++;

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    function automatic void sb_push(input int disp_t, input logic roll);
        snap_t e;
        e.cs   = to_bcd(disp_t % 100);
        e.sec  = to_bcd((disp_t / 100) % 60);
        e.min  = to_bcd(disp_t / 6000);
        e.run  = (m_state == 1);
        e.roll = roll;
        sb_q.push_back(e);
    endfunction

    task automatic ticks(input int n, input int hi, input int lo);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); clk_100Hz = 1'b1;
            if (m_state == 1) m_t = (m_t + 1) % WRAP;
            repeat (hi - 1) @(negedge clk);
            @(negedge clk); clk_100Hz = 1'b0;
            repeat (lo - 1) @(negedge clk);
        end
    endtask

    task automatic pulse_ss();
        @(negedge clk); start_stop = 1'b1;
        @(negedge clk); start_stop = 1'b0;
        m_state = (m_state == 1) ? 2 : 1;
    endtask

    task automatic pulse_clear();
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        m_t = 0; m_state = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; clk_100Hz = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        m_t = 0; m_state = 0;
        @(negedge clk);
        sb_push(m_t, 1'b0);
        obs = {cs_bcd, sec_bcd, min_bcd, running, rollover}; expv = sb_q.pop_front();
        n_checks++;
        if (obs !== expv) begin n_fail++; $display("FAIL reset_state: got %h required %h", obs, expv); end
        clk_100Hz = 1'b0;
        @(negedge clk);
        ticks(3, 2, 3);
        sb_push(m_t, 1'b0);
        obs = {cs_bcd, sec_bcd, min_bcd, running, rollover}; expv = sb_q.pop_front();
        n_checks++;
        if (obs !== expv) begin n_fail++; $display("FAIL idle_no_count: got %h required %h", obs, expv); end
    endtask

    task automatic test_count_1s();
        pulse_ss();
        ticks(100, 2, 3);
        sb_push(m_t, 1'b0);
        obs = {cs_bcd, sec_bcd, min_bcd, running, rollover}; expv = sb_q.pop_front();
        n_checks++;
        if (obs !== expv) begin n_fail++; $display("FAIL count_1s: got %h required %h", obs, expv); end
    endtask

    task automatic test_pause();
        pulse_clear();
        pulse_ss();
        ticks(37, 2, 3);
        pulse_ss();
        ticks(20, 2, 3);
        sb_push(m_t, 1'b0);
        obs = {cs_bcd, sec_bcd, min_bcd, running, rollover}; expv = sb_q.pop_front();
        n_checks++;
        if (obs !== expv) begin n_fail++; $display("FAIL pause_hold: got %h required %h", obs, expv); end
        pulse_ss();
        ticks(63, 2, 3);
        sb_push(m_t, 1'b0);
        obs = {cs_bcd, sec_bcd, min_bcd, running, rollover}; expv = sb_q.pop_front();
        n_checks++;
        if (obs !== expv) begin n_fail++; $display("FAIL resume_count: got %h required %h", obs, expv); end
    endtask

    task automatic test_tick_ss_coincide();
        pulse_clear();
        pulse_ss();
        ticks(10, 2, 2);
        // tick with start_stop in RUN: counted, then pause
        @(negedge clk); clk_100Hz = 1'b1; start_stop = 1'b1;
        m_t = m_t + 1; m_state = 2;
        @(negedge clk); start_stop = 1'b0;
        sb_push(m_t, 1'b0);
        obs = {cs_bcd, sec_bcd, min_bcd, running, rollover}; expv = sb_q.pop_front();
        n_checks++;
        if (obs !== expv) begin n_fail++; $display("FAIL tick_ss_in_run: got %h required %h", obs, expv); end
        @(negedge clk); clk_100Hz = 1'b0;
        @(negedge clk);
        // tick with start_stop in PAUSE: not counted, resume
        @(negedge clk); clk_100Hz = 1'b1; start_stop = 1'b1;
        m_state = 1;
        @(negedge clk); start_stop = 1'b0;
        sb_push(m_t, 1'b0);
        obs = {cs_bcd, sec_bcd, min_bcd, running, rollover}; expv = sb_q.pop_front();
        n_checks++;
        if (obs !== expv) begin n_fail++; $display("FAIL tick_ss_in_pause: got %h required %h", obs, expv); end
        @(negedge clk); clk_100Hz = 1'b0;
        @(negedge clk);
        ticks(1, 1, 2);
        sb_push(m_t, 1'b0);
        obs = {cs_bcd, sec_bcd, min_bcd, running, rollover}; expv = sb_q.pop_front();
        n_checks++;
        if (obs !== expv) begin n_fail++; $display("FAIL post_resume_tick: got %h required %h", obs, expv); end
    endtask

    task automatic test_clear_priority();
        pulse_clear();
        pulse_ss();
        ticks(45, 2, 3);
        sb_push(m_t, 1'b0);
        obs = {cs_bcd, sec_bcd, min_bcd, running, rollover}; expv = sb_q.pop_front();
        n_checks++;
        if (obs !== expv) begin n_fail++; $display("FAIL pre_clear_45: got %h required %h", obs, expv); end
        @(negedge clk); clear = 1'b1; start_stop = 1'b1; clk_100Hz = 1'b1;
        @(negedge clk); clear = 1'b0; start_stop = 1'b0;
        m_t = 0; m_state = 0;
        sb_push(m_t, 1'b0);
        obs = {cs_bcd, sec_bcd, min_bcd, running, rollover}; expv = sb_q.pop_front();
        n_checks++;
        if (obs !== expv) begin n_fail++; $display("FAIL clear_priority: got %h required %h", obs, expv); end
        @(negedge clk); clk_100Hz = 1'b0;
        ticks(5, 2, 2);
        sb_push(m_t, 1'b0);
        obs = {cs_bcd, sec_bcd, min_bcd, running, rollover}; expv = sb_q.pop_front();
        n_checks++;
        if (obs !== expv) begin n_fail++; $display("FAIL idle_after_clear: got %h required %h", obs, expv); end
    endtask

    task automatic test_rollover();
        pulse_clear();
        roll_cnt = 0;
        pulse_ss();
        ticks(WRAP - 1, 1, 1);
        @(negedge clk);
        sb_push(m_t, 1'b0);
        obs = {cs_bcd, sec_bcd, min_bcd, running, rollover}; expv = sb_q.pop_front();
        n_checks++;
        if (obs !== expv) begin n_fail++; $display("FAIL max_count: got %h required %h", obs, expv); end
        n_checks++;
        if (roll_cnt !== 0) begin n_fail++; $display("FAIL no_early_rollover: got %0d required 0", roll_cnt); end
        @(negedge clk); clk_100Hz = 1'b1;
        m_t = (m_t + 1) % WRAP;
        @(negedge clk); clk_100Hz = 1'b0;
        sb_push(m_t, 1'b1);
        obs = {cs_bcd, sec_bcd, min_bcd, running, rollover}; expv = sb_q.pop_front();
        n_checks++;
        if (obs !== expv) begin n_fail++; $display("FAIL wrap_pulse: got %h required %h", obs, expv); end
        @(negedge clk);
        sb_push(m_t, 1'b0);
        obs = {cs_bcd, sec_bcd, min_bcd, running, rollover}; expv = sb_q.pop_front();
        n_checks++;
        if (obs !== expv) begin n_fail++; $display("FAIL wrap_pulse_end: got %h required %h", obs, expv); end
        ticks(1, 1, 3);
        sb_push(m_t, 1'b0);
        obs = {cs_bcd, sec_bcd, min_bcd, running, rollover}; expv = sb_q.pop_front();
        n_checks++;
        if (obs !== expv) begin n_fail++; $display("FAIL count_after_wrap: got %h required %h", obs, expv); end
        n_checks++;
        if (roll_cnt !== 1) begin n_fail++; $display("FAIL rollover_count: got %0d required 1", roll_cnt); end
    endtask

    task automatic test_reset_mid();
        ticks(7, 1, 2);
        @(negedge clk); rst = 1'b1; clk_100Hz = 1'b1; start_stop = 1'b1;
        @(negedge clk); rst = 1'b0; start_stop = 1'b0;
        m_t = 0; m_state = 0;
        sb_push(m_t, 1'b0);
        obs = {cs_bcd, sec_bcd, min_bcd, running, rollover}; expv = sb_q.pop_front();
        n_checks++;
        if (obs !== expv) begin n_fail++; $display("FAIL reset_mid_count: got %h required %h", obs, expv); end
        @(negedge clk); clk_100Hz = 1'b0;
        @(negedge clk);
    endtask

`ifdef LAP_HOLD_EN
    task automatic test_lap();
        pulse_clear();
        pulse_ss();
        ticks(25, 2, 3);
        @(negedge clk); lap = 1'b1;
        @(negedge clk); lap = 1'b0;
        m_hold = m_t;
        ticks(50, 2, 3);
        sb_push(m_hold, 1'b0);
        obs = {cs_bcd, sec_bcd, min_bcd, running, rollover}; expv = sb_q.pop_front();
        n_checks++;
        if (obs !== expv) begin n_fail++; $display("FAIL lap_hold: got %h required %h", obs, expv); end
        @(negedge clk); lap = 1'b1;
        @(negedge clk); lap = 1'b0;
        sb_push(m_t, 1'b0);
        obs = {cs_bcd, sec_bcd, min_bcd, running, rollover}; expv = sb_q.pop_front();
        n_checks++;
        if (obs !== expv) begin n_fail++; $display("FAIL lap_release: got %h required %h", obs, expv); end
    endtask
`endif

    initial begin
        test_reset();
        test_count_1s();
        test_pause();
        test_tick_ss_coincide();
        test_clear_priority();
        test_rollover();
        test_reset_mid();
`ifdef LAP_HOLD_EN
        test_lap();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
